// File: rtl/return_addr_stack.sv
// ============================================================================
// Module      : return_addr_stack
// Description : Circular return-address stack with speculative push/pop
//               rollback on pipeline flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module return_addr_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int RB_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic [RB_W-1:0]          rb_push_n,
   input  logic [RB_W-1:0]          rb_pop_n,
   output logic [WIDTH-1:0]         top,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = RB_W + PTR_W + 2;

   localparam logic [PTR_W-1:0]        PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]        CNT_DEPTH = CNT_W'(DEPTH);
   localparam logic signed [SUM_W-1:0] SUM_DEPTH = SUM_W'(DEPTH);

   logic [WIDTH-1:0]        mem_q [DEPTH];
   logic [WIDTH-1:0]        mem_d [DEPTH];
   logic [PTR_W-1:0]        ptr_q,       ptr_d;
   logic [CNT_W-1:0]        count_q,     count_d;
   logic                    overflow_q,  overflow_d;
   logic                    underflow_q, underflow_d;

   logic [PTR_W-1:0]        top_idx;
   logic signed [SUM_W-1:0] cnt_sum;
   logic                    is_empty;
   logic                    is_full;

   assign top_idx  = ptr_q - PTR_ONE;
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_DEPTH);

   // Rollback count is evaluated wide and signed so it can go negative or
   // beyond DEPTH before being clamped back into range.
   assign cnt_sum = $signed({{(SUM_W-CNT_W){1'b0}}, count_q})
                  + $signed({{(SUM_W-RB_W){1'b0}}, rb_pop_n})
                  - $signed({{(SUM_W-RB_W){1'b0}}, rb_push_n});

   always_comb begin
      mem_d       = mem_q;
      ptr_d       = ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = 1'b0;

      if (flush) begin
         ptr_d = ptr_q + PTR_W'(rb_pop_n) - PTR_W'(rb_push_n);
         if (cnt_sum[SUM_W-1]) begin
            count_d = '0;
         end else if (cnt_sum > SUM_DEPTH) begin
            count_d = CNT_DEPTH;
         end else begin
            count_d = cnt_sum[CNT_W-1:0];
         end
      end else if (!stall) begin
         if (push && pop && !is_empty) begin
            // Co-routine call/return: replace the top in place.
            mem_d[top_idx] = push_data;
         end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_ONE;
            if (is_full) begin
               overflow_d = 1'b1;
            end else begin
               count_d = count_q + CNT_ONE;
            end
         end else if (pop) begin
            if (is_empty) begin
               underflow_d = 1'b1;
            end else begin
               ptr_d   = top_idx;
               count_d = count_q - CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         ptr_q       <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign top       = is_empty ? '0 : mem_q[top_idx];
   assign count     = count_q;
   assign empty     = is_empty;
   assign full      = is_full;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_return_addr_stack.sv
// ============================================================================
// Module      : tb_return_addr_stack
// Description : Directed self-checking bench for return_addr_stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_return_addr_stack;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int RB_W  = 2;

   logic             clk;
   logic             rst_n;
   logic             stall;
   logic             flush;
   logic             push;
   logic [WIDTH-1:0] push_data;
   logic             pop;
   logic [RB_W-1:0]  rb_push_n;
   logic [RB_W-1:0]  rb_pop_n;
   logic [WIDTH-1:0] top;
   logic [3:0]       count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   int checks = 0;
   int errors = 0;

   return_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RB_W(RB_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .flush     (flush),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .rb_push_n (rb_push_n),
      .rb_pop_n  (rb_pop_n),
      .top       (top),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of stimulus, then return to idle 1ns after the edge.
   task automatic cyc(input logic p_push, input logic p_pop, input logic p_stall,
                      input logic p_flush, input logic [31:0] p_data,
                      input logic [1:0] p_rbpush, input logic [1:0] p_rbpop);
      push      = p_push;
      pop       = p_pop;
      stall     = p_stall;
      flush     = p_flush;
      push_data = p_data;
      rb_push_n = p_rbpush;
      rb_pop_n  = p_rbpop;
      @(posedge clk);
      #1;
      push = 0; pop = 0; stall = 0; flush = 0;
      push_data = '0; rb_push_n = '0; rb_pop_n = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; stall = 0; flush = 0; push = 0; pop = 0;
      push_data = '0; rb_push_n = '0; rb_pop_n = '0;

      // Reset state
      do_reset();
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full",  32'(full), 0);
      chk("rst_top",   top, 0);
      chk("rst_ovf",   32'(overflow), 0);
      chk("rst_unf",   32'(underflow), 0);

      // Basic push/pop
      cyc(1, 0, 0, 0, 32'h100, 0, 0);
      chk("push1_top", top, 32'h100);
      cyc(1, 0, 0, 0, 32'h200, 0, 0);
      cyc(1, 0, 0, 0, 32'h300, 0, 0);
      chk("push3_count", 32'(count), 3);
      chk("push3_top",   top, 32'h300);
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("pop_top",   top, 32'h200);
      chk("pop_count", 32'(count), 2);

      // Fill, wrap with overflow, drain, underflow
      do_reset();
      for (int k = 1; k <= 8; k++) cyc(1, 0, 0, 0, 32'(k * 16), 0, 0);
      chk("fill_full",  32'(full), 1);
      chk("fill_ovf",   32'(overflow), 0);
      chk("fill_count", 32'(count), 8);
      cyc(1, 0, 0, 0, 32'h90, 0, 0);
      chk("wrap_full",  32'(full), 1);
      chk("wrap_ovf",   32'(overflow), 1);
      chk("wrap_count", 32'(count), 8);
      chk("wrap_top",   top, 32'h90);
      for (int k = 1; k <= 7; k++) begin
         cyc(0, 1, 0, 0, 0, 0, 0);
         chk("drain_top", top, 32'(32'h90 - k * 16));
      end
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("drain_empty", 32'(empty), 1);
      chk("drain_top0",  top, 0);
      chk("drain_unf0",  32'(underflow), 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("unf_pulse", 32'(underflow), 1);
      chk("unf_count", 32'(count), 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("unf_clear", 32'(underflow), 0);
      // Undo 3 pops: entries 0x20..0x40 reappear, overflow stays sticky
      cyc(0, 0, 0, 1, 0, 0, 3);
      chk("undo_count", 32'(count), 3);
      chk("undo_top",   top, 32'h40);
      chk("flush_ovf",  32'(overflow), 1);

      // Rollback of popped entries and low clamp
      do_reset();
      cyc(1, 0, 0, 0, 32'hA0, 0, 0);
      cyc(1, 0, 0, 0, 32'hB0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("rb_pre_empty", 32'(empty), 1);
      cyc(0, 0, 0, 1, 0, 0, 2);
      chk("rb_count", 32'(count), 2);
      chk("rb_top",   top, 32'hB0);
      cyc(0, 0, 0, 1, 0, 3, 0);
      chk("clamp_lo_count", 32'(count), 0);
      chk("clamp_lo_top",   top, 0);
      cyc(1, 0, 0, 0, 32'hE0, 0, 0);
      chk("after_clamp_top",   top, 32'hE0);
      chk("after_clamp_count", 32'(count), 1);

      // High clamp: full stack, undo 3 pops
      do_reset();
      for (int k = 1; k <= 8; k++) cyc(1, 0, 0, 0, 32'(k), 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 3);
      chk("clamp_hi_count", 32'(count), 8);
      chk("clamp_hi_top",   top, 32'h3);

      // Flush and stall squash push/pop
      do_reset();
      cyc(1, 0, 0, 0, 32'hA0, 0, 0);
      cyc(1, 0, 0, 1, 32'hC4, 0, 0);
      chk("flush_sq_top",   top, 32'hA0);
      chk("flush_sq_count", 32'(count), 1);
      cyc(1, 0, 1, 0, 32'hC4, 0, 0);
      chk("stall_push_top",   top, 32'hA0);
      chk("stall_push_count", 32'(count), 1);
      cyc(0, 1, 1, 0, 0, 0, 0);
      chk("stall_pop_count", 32'(count), 1);

      // Simultaneous push+pop
      cyc(1, 1, 0, 0, 32'hD8, 0, 0);
      chk("pp_top",   top, 32'hD8);
      chk("pp_count", 32'(count), 1);
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("pp_drain_empty", 32'(empty), 1);
      cyc(1, 1, 0, 0, 32'hD8, 0, 0);
      chk("pp_empty_count", 32'(count), 1);
      chk("pp_empty_top",   top, 32'hD8);
      chk("pp_empty_unf",   32'(underflow), 0);

      // Stalled or flushed pop on an empty stack never underflows
      do_reset();
      cyc(0, 1, 1, 0, 0, 0, 0);
      chk("stall_unf", 32'(underflow), 0);
      cyc(0, 1, 0, 1, 0, 0, 0);
      chk("flush_unf", 32'(underflow), 0);

      // Reset wins over push and flush
      for (int k = 0; k < 9; k++) cyc(1, 0, 0, 0, 32'h55, 0, 0);
      chk("pre_rst_ovf", 32'(overflow), 1);
      rst_n = 1'b0;
      cyc(1, 0, 0, 1, 32'h77, 0, 1);
      rst_n = 1'b1;
      chk("rst_win_count", 32'(count), 0);
      chk("rst_win_empty", 32'(empty), 1);
      chk("rst_win_ovf",   32'(overflow), 0);
      chk("rst_win_top",   top, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 Parameter WIDTH, default 32: return-address width in bits.
REQ-002 Parameter DEPTH, default 8: entry count; power of two, >= 2.
REQ-003 Parameter RB_W, default 2: width of each rollback-count input.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 stall  input  1  pipeline stall; freezes push/pop.
REQ-007 flush  input  1  pipeline flush; applies rollback counts, squashes push/pop.
REQ-008 push  input  1  call detected in fetch; push push_data.
REQ-009 push_data  input  WIDTH  return address (pc+4) to push.
REQ-010 pop  input  1  return detected in fetch; pop top.
REQ-011 rb_push_n  input  RB_W  number of speculative pushes to undo on flush.
REQ-012 rb_pop_n  input  RB_W  number of speculative pops to undo on flush.
REQ-013 top  output  WIDTH  predicted return address, mem[(ptr-1) mod DEPTH]; 0 when empty.
REQ-014 count  output  $clog2(DEPTH)+1  valid entries, 0..DEPTH.
REQ-015 empty  output  1  count==0.
REQ-016 full  output  1  count==DEPTH.
REQ-017 overflow  output  1  sticky: set when an entry was overwritten by a push while full.
REQ-018 underflow  output  1  one-cycle pulse: pop attempted while empty.

Function
REQ-019 State SHALL be: circular array mem[DEPTH] of WIDTH bits; ptr ($clog2(DEPTH) bits, next free slot, wraps mod DEPTH); count; overflow; underflow.
REQ-020 top, empty, full, count SHALL be combinational from registered state; a push/pop is visible on top the cycle after its edge.
REQ-021 Priority per cycle SHALL be: flush > stall > push/pop.
REQ-022 Push only (flush=0, stall=0): mem[ptr]<=push_data; ptr<=ptr+1; count<=min(count+1,DEPTH).
REQ-023 Push while full SHALL overwrite the oldest entry (wrap), keep count=DEPTH, and set overflow.
REQ-024 Pop only: if count>0, ptr<=ptr-1, count<=count-1, mem unchanged; if count==0, no state change, underflow=1 next cycle.
REQ-025 Push and pop together (jalr co-routine): if count>0, mem[ptr-1]<=push_data, ptr/count unchanged; if count==0, behave as push only, no underflow.
REQ-026 stall=1, flush=0: no change to mem, ptr, count; underflow SHALL be 0 next cycle.
REQ-027 flush=1: push/pop ignored; ptr<=(ptr+rb_pop_n-rb_push_n) mod DEPTH; count<=clamp(count+rb_pop_n-rb_push_n, 0, DEPTH); mem unchanged.
REQ-028 Undone pops SHALL expose previously popped data since pop never erases mem; entries overwritten after a pop are not restored.
REQ-029 underflow SHALL be 0 in every cycle not directly following a REQ-024 underflow event.
REQ-030 overflow SHALL remain 1 until reset; flush does not clear it.
REQ-031 All arithmetic on ptr SHALL be modulo DEPTH; count arithmetic SHALL be computed signed with RB_W+$clog2(DEPTH)+2 bits before clamping.

Reset
REQ-032 rst_n=0 at a rising edge SHALL set ptr=0, count=0, all mem=0, overflow=0, underflow=0; outputs: top=0, empty=1, full=0.
REQ-033 Reset SHALL take precedence over flush, stall, push, pop in the same cycle, including mid-sequence.

Verification
REQ-034 Reset, push 0x100,0x200,0x300 -> count=3, top=0x300; pop -> top=0x200, count=2.
REQ-035 DEPTH=8: push 0x10..0x90 (9 pushes) -> full=1, overflow=1, count=8, top=0x90; 8 pops -> empty=1, top=0; 9th pop -> underflow=1 for exactly one cycle.
REQ-036 Push 0xA0, push 0xB0, pop, pop, flush with rb_pop_n=2, rb_push_n=0 -> count=2, top=0xB0.
REQ-037 Count=1 (top=0xA0), push 0xC4 and flush=1 with rb_push_n=0,rb_pop_n=0 in the same cycle -> no change, top=0xA0; push with stall=1 -> no change.
REQ-038 top=0xA0, push+pop same cycle with push_data=0xD8 -> top=0xD8, count unchanged; on empty stack -> count=1, top=0xD8, underflow=0.
REQ-039 rst_n=0 asserted while push=1 and flush=1 -> next cycle count=0, empty=1, overflow=0.
